seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the 4-digit seven-segment display. It accepts display contents through a valid/ready load port into a shadow buffer and commits them atomically at frame boundaries. It then drives the anodes one digit at a time, with a programmable dwell and an anti-ghosting blanking interval. It sits between the arithmetic/result logic (producers of A/B-style nibbles) and the board pins.

## Interface
- CLK_DIV, 50000, clock cycles per digit slot; must be ≥ BLANK_CYC+1
- BLANK_CYC, 16, cycles at slot start with all anodes off; must be ≥ 1
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  producer has new display contents
- load_ready  out  1  shadow buffer can accept; transfer occurs when load_valid && load_ready
- load_data  in  16  four hex nibbles; digit 0 = [3:0], digit 3 = [15:12]
- load_dp  in  4  decimal point per digit, 1 = lit
- load_en  in  4  digit enable per digit, 1 = shown
- seven_segment  out  7  active-low segments, bit 0 = a … bit 6 = g
- dp  out  1  active-low decimal point
- an  out  4  active-low anodes, an[i] = digit i
- frame_done  out  1  one-cycle pulse in the last cycle of the digit-3 slot

## Operation
- Registers:
  - active set (data/dp/en), reset 0, so the display is dark until the first load
  - pending set plus pend_full flag
  - slot counter cnt: 0..CLK_DIV-1
  - digit index idx: 0..3, wraps 3→0
  - FSM state
- FSM:
  - BLANK (cnt < BLANK_CYC): an=4'hF, seven_segment=7'h7F, dp=1
  - SHOW: an[idx]=0 if en[idx], else an=4'hF; segments = hex decode of active nibble; dp = ~dp[idx]
  - BLANK→SHOW when cnt = BLANK_CYC-1
  - SHOW→BLANK when cnt = CLK_DIV-1, at which point cnt→0 and idx increments
- Hex decode is active-low gfedcba: 0→7'b1000000, 3→7'b0110000, 4→7'b0011001, 7→7'b1111000, 8→7'b0000000, F→7'b0001110.
- Handshake:
  - load_ready = ~pend_full; on transfer, pend_full sets.
  - At the frame boundary (cnt = CLK_DIV-1, idx = 3) with pend_full set, pending copies to active and pend_full clears; load_ready is 1 on the next cycle.
- Simultaneous transfer and frame boundary with pend_full clear: data goes to pending and is committed at the following boundary. There is no bypass; a frame never mixes old and new contents.
- Producer must hold load_* stable while load_valid && !load_ready.
- Reset values: an=4'hF, seven_segment=7'h7F, dp=1, frame_done=0, load_ready=0 while rst is high; cnt=0, idx=0, state BLANK, pend_full=0.
- Reset mid-operation aborts the slot and discards pending data.

## Timing
- All outputs are registered and reflect cnt/idx/state of the previous cycle.
- The first cycle after rst falls is blank.
- Per slot: exactly BLANK_CYC blank cycles, then CLK_DIV-BLANK_CYC shown cycles.
- Frame period is 4·CLK_DIV cycles; frame_done fires once per frame.
- Disabled digits keep their slot timing, with anodes off.
- Load-to-display latency: from acceptance, until the end of the current frame plus one cycle. Worst case is 4·CLK_DIV+1.

## Configuration
- SEG_SCAN_LZB_EN defined: leading-zero blanking. An enabled digit i>0 whose nibble is 0 is forced dark (an=4'hF, segments 7'h7F) when all higher digits are 0 or disabled. Its dp is still driven. Digit 0 is never blanked.
- SEG_SCAN_LZB_EN undefined: every enabled digit shows its nibble, including leading zeros.

## Structure
- Package seg_scan_pkg holds:
  - the FSM state enum {BLANK, SHOW}
  - NUM_DIGITS=4
  - SEG_BLANK=7'h7F
  - the 16-entry active-low hex segment table
- Sub-module seg_hex_decode: combinational 4-bit→7-bit decode, instantiated once on the selected nibble.

## Test plan
Run all scenarios with CLK_DIV=8, BLANK_CYC=2.
1. Reset, then release → an=4'hF, seven_segment=7'h7F, dp=1, load_ready 0 during rst and 1 afterwards; display stays dark for a full frame.
2. Load 16'h1234, dp 4'b0001, en 4'hF mid-frame → from the next frame:
   - slot 0: 2 blank cycles, then 6 cycles of an=4'b1110, seg 7'b0011001, dp=0
   - slot 1: 7'b0110000, dp=1
   - frame_done every 32 cycles
3. Two back-to-back loads → second sees load_ready=0 until the frame boundary; it commits one frame after the first, and no frame shows mixed contents.
4. en=4'b0101 → slots 1 and 3 keep an=4'hF for their full 8 cycles; digits 0 and 2 are displayed.
5. 16'h0070, en 4'hF: with SEG_SCAN_LZB_EN, digits 3 and 2 are dark, digit 1 shows 7'b1111000, digit 0 shows 7'b1000000; without it, all four digits are shown.
6. Assert rst for one cycle mid-SHOW with pending full → next cycle has reset outputs; the pending data never appears.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package seg_scan_pkg;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_e;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment (gfedcba) decoder.
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller with a shadow load buffer.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    input  logic [3:0]  load_en,
    output logic [6:0]  seven_segment,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int            CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [1:0]    IDX_LAST   = 2'(NUM_DIGITS - 1);

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   act_data_q, act_data_d;
    logic [3:0]    act_dp_q, act_dp_d;
    logic [3:0]    act_en_q, act_en_d;
    logic [15:0]   pend_data_q, pend_data_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic [3:0]    pend_en_q, pend_en_d;
    logic          pend_full_q, pend_full_d;
    logic          load_ready_q, load_ready_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;

    logic          last_cnt;
    logic          boundary;
    logic          load_fire;
    logic [3:0]    sel_nib;
    logic [6:0]    dec_seg;
    logic          lz_blank;

    assign last_cnt  = (cnt_q == CNT_LAST);
    assign boundary  = last_cnt && (idx_q == IDX_LAST);
    assign load_fire = load_valid && load_ready_q;
    assign sel_nib   = act_data_q[{idx_q, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .nibble (sel_nib),
        .seg    (dec_seg)
    );

    // A zero digit is dark only when every more-significant digit is zero or off.
    always_comb begin
        lz_blank = 1'b0;
`ifdef SEG_SCAN_LZB_EN
        if (idx_q != 2'd0 && act_en_q[idx_q] && sel_nib == 4'h0) begin
            lz_blank = 1'b1;
            for (int j = 1; j < NUM_DIGITS; j++) begin
                if (j > int'(idx_q) && act_en_q[j] && act_data_q[4*j +: 4] != 4'h0)
                    lz_blank = 1'b0;
            end
        end
`endif
    end

    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_full_d  = pend_full_q;
        cnt_d        = last_cnt ? '0 : cnt_q + 1'b1;
        idx_d        = last_cnt ? idx_q + 2'd1 : idx_q;

        case (state_q)
            BLANK:   if (cnt_q == BLANK_LAST) state_d = SHOW;
            SHOW:    if (last_cnt) state_d = BLANK;
            default: state_d = BLANK;
        endcase

        // Commit and capture are exclusive: a capture needs pend_full clear.
        if (boundary && pend_full_q) begin
            act_data_d  = pend_data_q;
            act_dp_d    = pend_dp_q;
            act_en_d    = pend_en_q;
            pend_full_d = 1'b0;
        end else if (load_fire) begin
            pend_data_d = load_data;
            pend_dp_d   = load_dp;
            pend_en_d   = load_en;
            pend_full_d = 1'b1;
        end
        load_ready_d = ~pend_full_d;

        an_d         = 4'hF;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        frame_done_d = boundary;
        if (state_q == SHOW) begin
            seg_d = lz_blank ? SEG_BLANK : dec_seg;
            dp_d  = ~act_dp_q[idx_q];
            if (act_en_q[idx_q] && !lz_blank)
                an_d[idx_q] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            pend_full_q  <= 1'b0;
            load_ready_q <= 1'b0;
            an_q         <= 4'hF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            pend_full_q  <= pend_full_d;
            load_ready_q <= load_ready_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the pending buffer is not reset; pend_full_q marks whether its contents are valid.
    always_ff @(posedge clk) begin
        pend_data_q <= pend_data_d;
        pend_dp_q   <= pend_dp_d;
        pend_en_q   <= pend_en_d;
    end

    assign load_ready    = load_ready_q;
    assign an            = an_q;
    assign seven_segment = seg_q;
    assign dp            = dp_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: randomized loads against a frame-time reference model.
// Honours SEG_SCAN_LZB_EN the same way the design does.
module tb_seg_scan_ctrl;

    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic [3:0]  load_dp = '0;
    logic [3:0]  load_en = '0;
    logic [6:0]  seven_segment;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: time since reset plus active/pending display sets.
    int          k = 0;
    logic [15:0] m_act_data = '0, m_pend_data = '0;
    logic [3:0]  m_act_dp = '0, m_act_en = '0, m_pend_dp = '0, m_pend_en = '0;
    bit          m_pend_full = 1'b0;
    bit          m_ready = 1'b0;
    logic [13:0] e_vec = '0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_dp       (load_dp),
        .load_en       (load_en),
        .seven_segment (seven_segment),
        .dp            (dp),
        .an            (an),
        .frame_done    (frame_done)
    );

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

`ifdef SEG_SCAN_LZB_EN
    function automatic bit leading_zero(input int d);
        if (d == 0 || !m_act_en[d] || m_act_data[4*d +: 4] != 4'h0) return 1'b0;
        for (int j = d + 1; j < 4; j++)
            if (m_act_en[j] && m_act_data[4*j +: 4] != 4'h0) return 1'b0;
        return 1'b1;
    endfunction
`endif

    function automatic logic [13:0] obs();
        return {an, seven_segment, dp, frame_done, load_ready};
    endfunction

    // Predict outputs after the coming edge, apply the edge to the model, advance the clock.
    task automatic tick();
        int p, d, s;
        bit lzb;
        logic [3:0] x_an;
        logic [6:0] x_seg;
        logic       x_dp, x_fd;
        x_an = 4'hF; x_seg = 7'h7F; x_dp = 1'b1; x_fd = 1'b0;
        if (rst) begin
            k = 0;
            m_pend_full = 1'b0;
            m_act_data = '0; m_act_dp = '0; m_act_en = '0;
            m_ready = 1'b0;
        end else begin
            p = k % FRAME;
            d = p / CLK_DIV;
            s = p % CLK_DIV;
            x_fd = (p == FRAME - 1);
            if (s >= BLANK_CYC) begin
                lzb = 1'b0;
`ifdef SEG_SCAN_LZB_EN
                lzb = leading_zero(d);
`endif
                x_seg = lzb ? 7'h7F : hex_seg(m_act_data[4*d +: 4]);
                x_dp  = ~m_act_dp[d];
                if (m_act_en[d] && !lzb) x_an[d] = 1'b0;
            end
            if (p == FRAME - 1 && m_pend_full) begin
                m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_en = m_pend_en;
                m_pend_full = 1'b0;
            end else if (load_valid && m_ready) begin
                m_pend_data = load_data; m_pend_dp = load_dp; m_pend_en = load_en;
                m_pend_full = 1'b1;
            end
            k++;
            m_ready = !m_pend_full;
        end
        e_vec = {x_an, x_seg, x_dp, x_fd, m_ready};
        @(posedge clk);
        @(negedge clk);
    endtask

    // Producer: present a load and hold it until the DUT accepts it.
    task automatic load_word(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        bit done = 1'b0;
        load_valid = 1'b1; load_data = d; load_dp = p; load_en = e;
        for (int i = 0; i < 4 * FRAME && !done; i++) begin
            done = load_ready;
            tick();
        end
        load_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL load_timeout: load_ready never seen high, wanted acceptance within %0d cycles", 4 * FRAME);
        end
    endtask

    task automatic sync_to(input int pos);
        for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== e_vec) begin
                errors++; $display("FAIL reset_hold k=%0d: got %b want %b", k, obs(), e_vec);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < FRAME + 4; i++) begin
            tick();
            checks++;
            if (obs() !== e_vec) begin
                errors++; $display("FAIL reset_release k=%0d: got %b want %b", k, obs(), e_vec);
            end
        end
    endtask

    task automatic test_load_basic();
        int pulses = 0;
        sync_to(12);
        load_word(16'h1234, 4'b0001, 4'hF);
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            tick();
            checks++;
            if (obs() !== e_vec) begin
                errors++; $display("FAIL load_basic k=%0d: got %b want %b", k, obs(), e_vec);
            end
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (frame_done) pulses++;
        end
        checks++;
        if (pulses !== 2) begin
            errors++; $display("FAIL frame_done_rate: got %0d pulses in 64 cycles, want 2", pulses);
        end
    endtask

    task automatic test_back_to_back();
        bit done = 1'b0;
        int waited = 0;
        sync_to(5);
        load_word(16'hABCD, 4'b1000, 4'hF);
        load_valid = 1'b1; load_data = 16'h5678; load_dp = 4'b0100; load_en = 4'hF;
        for (int i = 0; i < 4 * FRAME && !done; i++) begin
            done = load_ready;
            if (!done) waited++;
            tick();
            checks++;
            if (obs() !== e_vec) begin
                errors++; $display("FAIL back_to_back_wait k=%0d: got %b want %b", k, obs(), e_vec);
            end
        end
        load_valid = 1'b0;
        checks++;
        if (!done || waited == 0) begin
            errors++; $display("FAIL back_to_back_stall: accepted=%0d after %0d stalled cycles, want accepted after >0", done, waited);
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            checks++;
            if (obs() !== e_vec) begin
                errors++; $display("FAIL back_to_back_show k=%0d: got %b want %b", k, obs(), e_vec);
            end
        end
    endtask

    task automatic test_enable();
        load_word(16'h9876, 4'b1010, 4'b0101);
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            checks++;
            if (obs() !== e_vec) begin
                errors++; $display("FAIL enable_mask k=%0d: got %b want %b", k, obs(), e_vec);
            end
        end
    endtask

    task automatic test_lzb();
        load_word(16'h0070, 4'b0000, 4'hF);
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            checks++;
            if (obs() !== e_vec) begin
                errors++; $display("FAIL leading_zero k=%0d: got %b want %b", k, obs(), e_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        sync_to(3);
        load_word(16'hEEEE, 4'hF, 4'hF);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (obs() !== e_vec) begin
            errors++; $display("FAIL reset_mid k=%0d: got %b want %b", k, obs(), e_vec);
        end
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            tick();
            checks++;
            if (obs() !== e_vec) begin
                errors++; $display("FAIL reset_mid_after k=%0d: got %b want %b", k, obs(), e_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            load_word(16'($urandom), 4'($urandom), 4'($urandom));
            for (int i = 0; i < int'($urandom_range(0, 2 * FRAME)); i++) begin
                tick();
                checks++;
                if (obs() !== e_vec) begin
                    errors++; $display("FAIL random k=%0d: got %b want %b", k, obs(), e_vec);
                end
            end
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if (obs() !== e_vec) begin
                errors++; $display("FAIL random_tail k=%0d: got %b want %b", k, obs(), e_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_back_to_back();
        test_enable();
        test_lzb();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
